rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences the shared datapath (single memory port, ALU, register file, PC, sign-immediate generator) through fetch, decode, execute, memory and writeback.
- Decodes opcodes using the riscv_types package names: op_reg, op_imm, op_load, op_store, op_br, op_jump.
- Drives the memory request/ready handshake and counts retired instructions.

Parameters:
- WIDTH, 32, instruction width.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk_in  input  1  clock (the block's only clock).
- rst_in  input  1  reset; synchronous, active-high.
- instr_in  input  WIDTH  instruction register contents (valid from DECODE onward).
- mem_ready_in  input  1  memory completes the current request this cycle.
- branch_taken_in  input  1  ALU branch-compare result (valid in EXEC).
- mem_req_out  output  1  memory request.
- mem_we_out  output  1  memory write (store).
- mem_addr_sel_out  output  1  0 = PC, 1 = ALU result.
- ir_we_out  output  1  capture instruction and old PC; PC <= PC+4.
- ldr_we_out  output  1  capture load data.
- pc_we_out  output  1  PC write from target (old PC + imm).
- alu_src_b_out  output  1  0 = rs2, 1 = sign immediate.
- rf_we_out  output  1  register file write.
- wb_sel_out  output  2  0 = ALU, 1 = load data, 2 = PC (return address); 3 unused.
- illegal_out  output  1  sticky illegal-opcode flag.
- state_out  output  3  current state encoding.
- retired_out  output  CNT_WIDTH  retired-instruction count.

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Outputs are decoded from the state register plus mem_ready_in. With rst_in high, every output is 0.
- Reset: rst_in high at a clock edge sets state=FETCH, retired=0 and illegal=0, from any state. Any in-flight memory request is abandoned (mem_req_out drops in the reset cycle).
- FETCH:
  - mem_req_out=1, mem_addr_sel_out=0, mem_we_out=0.
  - While mem_ready_in=0, stay in FETCH.
  - When mem_ready_in=1: ir_we_out=1 in that same cycle, next state DECODE.
- DECODE (1 cycle): register read and immediate generation.
  - Opcode not in {op_reg, op_imm, op_load, op_store, op_br, op_jump} -> TRAP.
  - Otherwise -> EXEC.
- EXEC (1 cycle):
  - alu_src_b_out=1 for op_imm, op_load and op_store; 0 otherwise.
  - op_br: pc_we_out=branch_taken_in; -> FETCH; retire.
  - op_jump: pc_we_out=1, rf_we_out=1, wb_sel_out=2; -> FETCH; retire.
  - op_reg, op_imm -> WB.
  - op_load, op_store -> MEM.
- MEM:
  - mem_req_out=1, mem_addr_sel_out=1, mem_we_out=1 only for op_store.
  - Wait while mem_ready_in=0.
  - On ready: a store -> FETCH and retires; a load asserts ldr_we_out and -> WB.
- WB (1 cycle): rf_we_out=1; wb_sel_out=1 for op_load, 0 otherwise; -> FETCH; retire.
- TRAP: all strobes 0; illegal_out=1; held until reset.
- Handshake rules:
  - mem_req_out, mem_we_out and mem_addr_sel_out stay stable from assertion until the cycle mem_ready_in=1 is sampled.
  - mem_ready_in is ignored when mem_req_out=0.
- Retire: retired_out increments by 1 on each transition into FETCH caused by completion (not by reset). Wraps from all-ones to 0.
- Latency with zero-wait memory (ready in the first request cycle):
  - op_br / op_jump: 3 cycles.
  - op_reg / op_imm / op_store: 4 cycles.
  - op_load: 5 cycles.
  - Each wait cycle adds 1.

Test Plan:
- Reset, then addi (0x00500093) with ready always 1 -> state sequence 0,1,2,4,0; rf_we_out=1 only in cycle 4 with wb_sel_out=0, alu_src_b_out=1 in EXEC; retired_out=1.
- lw (0x0000A103), ready held low 2 cycles in both FETCH and MEM -> 9-cycle instruction; mem_addr_sel_out=1 in MEM; ldr_we_out pulses once; WB with wb_sel_out=1; retired_out increments.
- beq (0x00000463): branch_taken_in=1 -> pc_we_out=1 in EXEC and returns to FETCH after 3 cycles; repeat with branch_taken_in=0 -> pc_we_out stays 0 and still retires.
- jal (0x008000EF) -> EXEC asserts pc_we_out=1, rf_we_out=1, wb_sel_out=2 together; sw (0x00112023) -> mem_we_out=1 only in MEM; no rf_we_out.
- Opcode 0x0000007F -> TRAP after DECODE; illegal_out=1 held for 20 cycles; retired_out unchanged; rst_in clears it.
- rst_in asserted in the middle of MEM with mem_req_out=1 -> next cycle state_out=0 and retired_out=0. Also preload retired_out at all-ones via a long run with CNT_WIDTH=4 -> wraps to 0 after 16 retires.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rv_multicycle_ctrl (with riscv_types opcode package)
// Description : Main control FSM for the multi-cycle RV32I core. Sequences
//               the shared datapath through fetch, decode, execute, memory
//               and writeback, drives the memory request/ready handshake and
//               counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================

package riscv_types;
    localparam logic [6:0] op_reg   = 7'b0110011;
    localparam logic [6:0] op_imm   = 7'b0010011;
    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;
    localparam logic [6:0] op_br    = 7'b1100011;
    localparam logic [6:0] op_jump  = 7'b1101111;
endpackage

module rv_multicycle_ctrl #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [WIDTH-1:0]     instr_in,
    input  logic                 mem_ready_in,
    input  logic                 branch_taken_in,
    output logic                 mem_req_out,
    output logic                 mem_we_out,
    output logic                 mem_addr_sel_out,
    output logic                 ir_we_out,
    output logic                 ldr_we_out,
    output logic                 pc_we_out,
    output logic                 alu_src_b_out,
    output logic                 rf_we_out,
    output logic [1:0]           wb_sel_out,
    output logic                 illegal_out,
    output logic [2:0]           state_out,
    output logic [CNT_WIDTH-1:0] retired_out
);

    import riscv_types::*;

    localparam logic [2:0] c_fetch  = 3'd0;
    localparam logic [2:0] c_decode = 3'd1;
    localparam logic [2:0] c_exec   = 3'd2;
    localparam logic [2:0] c_mem    = 3'd3;
    localparam logic [2:0] c_wb     = 3'd4;
    localparam logic [2:0] c_trap   = 3'd5;

    localparam logic [1:0] c_wb_alu  = 2'd0;
    localparam logic [1:0] c_wb_load = 2'd1;
    localparam logic [1:0] c_wb_pc   = 2'd2;

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic                 w_retire;
    logic [CNT_WIDTH-1:0] r_retired;
    logic                 r_illegal;

    // Only the major opcode steers the sequencer; the remaining instruction
    // fields belong to the datapath.
    logic [6:0] w_opcode;
    logic       w_unused_instr;
    assign w_opcode       = instr_in[6:0];
    assign w_unused_instr = ^instr_in[WIDTH-1:7];

    logic w_is_reg, w_is_imm, w_is_load, w_is_store, w_is_br, w_is_jump;
    logic w_legal;
    assign w_is_reg   = (w_opcode == op_reg);
    assign w_is_imm   = (w_opcode == op_imm);
    assign w_is_load  = (w_opcode == op_load);
    assign w_is_store = (w_opcode == op_store);
    assign w_is_br    = (w_opcode == op_br);
    assign w_is_jump  = (w_opcode == op_jump);
    assign w_legal    = w_is_reg | w_is_imm | w_is_load | w_is_store |
                        w_is_br  | w_is_jump;

    // Next-state selection and detection of instruction completion.
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            c_fetch: begin
                if (mem_ready_in) w_next = c_decode;
            end
            c_decode: begin
                w_next = w_legal ? c_exec : c_trap;
            end
            c_exec: begin
                if (w_is_br || w_is_jump) begin
                    w_next   = c_fetch;
                    w_retire = 1'b1;
                end else if (w_is_reg || w_is_imm) begin
                    w_next = c_wb;
                end else if (w_is_load || w_is_store) begin
                    w_next = c_mem;
                end else begin
                    // The IR changed under us; nothing sensible to execute.
                    w_next = c_trap;
                end
            end
            c_mem: begin
                if (mem_ready_in) begin
                    if (w_is_store) begin
                        w_next   = c_fetch;
                        w_retire = 1'b1;
                    end else begin
                        w_next = c_wb;
                    end
                end
            end
            c_wb: begin
                w_next   = c_fetch;
                w_retire = 1'b1;
            end
            c_trap: begin
                w_next = c_trap;
            end
            default: begin
                // Unused encodings are treated as a fault, same as TRAP.
                w_next = c_trap;
            end
        endcase
    end

    // State, sticky illegal flag and wrapping retire counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= c_fetch;
            r_retired <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_retired <= r_retired + 1'b1;
            if (w_next == c_trap) r_illegal <= 1'b1;
        end
    end

    // Datapath strobes decoded from the state and the memory ready; all
    // forced low while reset is held so an in-flight request is dropped.
    always_comb begin
        mem_req_out      = 1'b0;
        mem_we_out       = 1'b0;
        mem_addr_sel_out = 1'b0;
        ir_we_out        = 1'b0;
        ldr_we_out       = 1'b0;
        pc_we_out        = 1'b0;
        alu_src_b_out    = 1'b0;
        rf_we_out        = 1'b0;
        wb_sel_out       = c_wb_alu;
        if (!rst_in) begin
            case (r_state)
                c_fetch: begin
                    mem_req_out = 1'b1;
                    ir_we_out   = mem_ready_in;
                end
                c_exec: begin
                    alu_src_b_out = w_is_imm | w_is_load | w_is_store;
                    if (w_is_br) begin
                        pc_we_out = branch_taken_in;
                    end else if (w_is_jump) begin
                        pc_we_out  = 1'b1;
                        rf_we_out  = 1'b1;
                        wb_sel_out = c_wb_pc;
                    end
                end
                c_mem: begin
                    mem_req_out      = 1'b1;
                    mem_addr_sel_out = 1'b1;
                    mem_we_out       = w_is_store;
                    ldr_we_out       = mem_ready_in & ~w_is_store;
                end
                c_wb: begin
                    rf_we_out  = 1'b1;
                    wb_sel_out = w_is_load ? c_wb_load : c_wb_alu;
                end
                default: begin
                end
            endcase
        end
    end

    assign illegal_out = r_illegal & ~rst_in;
    assign state_out   = rst_in ? 3'd0 : r_state;
    assign retired_out = rst_in ? '0 : r_retired;

endmodule

`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rv_multicycle_ctrl
// Description : Self-checking bench for rv_multicycle_ctrl: directed vector
//               table, hand-written corner sequences and randomized
//               instruction streams against a trace-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_rv_multicycle_ctrl;

    localparam int WIDTH = 32;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_in;
    logic [31:0]   instr_in;
    logic          mem_ready_in;
    logic          branch_taken_in;
    logic          mem_req_out, mem_we_out, mem_addr_sel_out, ir_we_out;
    logic          ldr_we_out, pc_we_out, alu_src_b_out, rf_we_out;
    logic [1:0]    wb_sel_out;
    logic          illegal_out;
    logic [2:0]    state_out;
    logic [CW-1:0] retired_out;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.WIDTH(WIDTH), .CNT_WIDTH(CW)) dut (
        .clk_in(clk), .rst_in(rst_in), .instr_in(instr_in),
        .mem_ready_in(mem_ready_in), .branch_taken_in(branch_taken_in),
        .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
        .mem_addr_sel_out(mem_addr_sel_out), .ir_we_out(ir_we_out),
        .ldr_we_out(ldr_we_out), .pc_we_out(pc_we_out),
        .alu_src_b_out(alu_src_b_out), .rf_we_out(rf_we_out),
        .wb_sel_out(wb_sel_out), .illegal_out(illegal_out),
        .state_out(state_out), .retired_out(retired_out)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // {state, req, we, asel, irwe, ldrwe, pcwe, srcb, rfwe, wbsel, illegal, retired}
    function automatic logic [17:0] pack_out();
        return {state_out, mem_req_out, mem_we_out, mem_addr_sel_out, ir_we_out,
                ldr_we_out, pc_we_out, alu_src_b_out, rf_we_out, wb_sel_out,
                illegal_out, retired_out};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // ---------------- trace-level reference model ----------------
    typedef struct {
        logic       rdy, tk;
        logic [2:0] st;
        logic       req, we, asel, irwe, ldrwe, pcwe, srcb, rfwe;
        logic [1:0] wbsel;
    } cyc_t;

    cyc_t exp_q[$];
    logic [6:0] opc [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};

    task automatic push(input logic rdy, tk, input logic [2:0] st,
                        input logic req, we, asel, irwe, ldrwe, pcwe, srcb, rfwe,
                        input logic [1:0] wbsel);
        cyc_t c;
        c = '{rdy, tk, st, req, we, asel, irwe, ldrwe, pcwe, srcb, rfwe, wbsel};
        exp_q.push_back(c);
    endtask

    // kind: 0 reg, 1 imm, 2 load, 3 store, 4 branch, 5 jump
    task automatic build_trace(input int kind, input int fw, input int mw, input logic taken);
        logic mem_op, wb_op;
        mem_op = (kind == 2) || (kind == 3);
        wb_op  = (kind <= 2);
        for (int i = 0; i < fw; i++) push(0, rb(), 0, 1,0,0,0,0,0,0,0, 2'd0);
        push(1, rb(), 0, 1,0,0,1,0,0,0,0, 2'd0);
        push(rb(), rb(), 1, 0,0,0,0,0,0,0,0, 2'd0);
        push(rb(), (kind == 4) ? taken : rb(), 2, 0,0,0,0,0,
             (kind == 4) ? taken : (kind == 5),
             (kind >= 1 && kind <= 3), (kind == 5),
             (kind == 5) ? 2'd2 : 2'd0);
        if (mem_op) begin
            for (int i = 0; i < mw; i++) push(0, rb(), 3, 1, (kind == 3), 1, 0,0,0,0,0, 2'd0);
            push(1, rb(), 3, 1, (kind == 3), 1, 0, (kind == 2), 0,0,0, 2'd0);
        end
        if (wb_op) push(rb(), rb(), 4, 0,0,0,0,0,0,0,1, (kind == 2) ? 2'd1 : 2'd0);
    endtask

    task automatic run_trace(input int kind);
        cyc_t c;
        logic [31:0] r;
        logic [3:0]  mc;
        r = $urandom();
        instr_in = {r[31:7], opc[kind]};
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            mem_ready_in    = c.rdy;
            branch_taken_in = c.tk;
            mc = model_cnt[3:0];
            #1;
            chk("trace", {14'd0, pack_out()},
                {14'd0, c.st, c.req, c.we, c.asel, c.irwe, c.ldrwe, c.pcwe,
                 c.srcb, c.rfwe, c.wbsel, 1'b0, mc});
            @(posedge clk); #1;
        end
        model_cnt++;
    endtask

    task automatic model_instr(input int kind, input int fw, input int mw, input logic taken);
        build_trace(kind, fw, mw, taken);
        run_trace(kind);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        mem_ready_in = 1'b1;
        branch_taken_in = 1'b1;
        #1;
        chk("reset_outputs_zero", {14'd0, pack_out()}, 32'd0);
        @(posedge clk); #1;
        rst_in = 1'b0;
        model_cnt = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] instr;
        int          fw, mw;
        logic        tk;
        int          cyc, npc, nrf, nldr, nwe, wbs, sb;
    } vec_t;

    initial begin
        vec_t vt[8];
        logic [3:0] r0, dr;
        vt[0] = '{32'h00500093, 0, 0, 1'b0, 4, 0, 1, 0, 0,  0, 1};
        vt[1] = '{32'h0000A103, 2, 2, 1'b0, 9, 0, 1, 1, 0,  1, 1};
        vt[2] = '{32'h00000463, 0, 0, 1'b1, 3, 1, 0, 0, 0, -1, 0};
        vt[3] = '{32'h00000463, 0, 0, 1'b0, 3, 0, 0, 0, 0, -1, 0};
        vt[4] = '{32'h008000EF, 0, 0, 1'b0, 3, 1, 1, 0, 0,  2, 0};
        vt[5] = '{32'h00112023, 0, 0, 1'b0, 4, 0, 0, 0, 1, -1, 1};
        vt[6] = '{32'h002081B3, 1, 0, 1'b0, 5, 0, 1, 0, 0,  0, 0};
        vt[7] = '{32'h00112023, 0, 3, 1'b0, 7, 0, 0, 0, 4, -1, 1};

        instr_in = 32'h0000007F;
        rst_in = 1'b1;
        mem_ready_in = 1'b1;
        branch_taken_in = 1'b1;
        @(posedge clk); #1;
        do_reset();
        mem_ready_in = 1'b0;
        #1;
        chk("post_reset_state", {29'd0, state_out}, 32'd0);
        chk("post_reset_retired", {28'd0, retired_out}, 32'd0);
        chk("post_reset_illegal", {31'd0, illegal_out}, 32'd0);
        chk("post_reset_fetch_req", {31'd0, mem_req_out}, 32'd1);

        // Directed table: whole-instruction latency and strobe counts.
        for (int v = 0; v < 8; v++) begin
            int fwl, mwl, cyc, npc, nrf, nldr, nwe, wbs, sb, bad;
            bit left, done;
            fwl = vt[v].fw; mwl = vt[v].mw;
            cyc = 0; npc = 0; nrf = 0; nldr = 0; nwe = 0; wbs = -1; sb = -1; bad = 0;
            left = 0; done = 0;
            r0 = retired_out;
            instr_in = vt[v].instr;
            while (!done && cyc < 60) begin
                if (state_out == 3'd0) begin
                    mem_ready_in = (fwl == 0); if (fwl > 0) fwl--;
                end else if (state_out == 3'd3) begin
                    mem_ready_in = (mwl == 0); if (mwl > 0) mwl--;
                end else begin
                    mem_ready_in = rb();
                end
                branch_taken_in = (state_out == 3'd2) ? vt[v].tk : rb();
                #1;
                if (pc_we_out) npc++;
                if (rf_we_out) begin nrf++; wbs = int'(wb_sel_out); end
                if (ldr_we_out) nldr++;
                if (mem_we_out) nwe++;
                if (state_out == 3'd2) sb = int'(alu_src_b_out);
                if ((state_out == 3'd3 && !mem_addr_sel_out) ||
                    (state_out != 3'd3 && mem_we_out)) bad++;
                if (state_out != 3'd0) left = 1;
                @(posedge clk); #1;
                cyc++;
                if (left && state_out == 3'd0) done = 1;
            end
            chk($sformatf("v%0d_done", v), 32'(done), 32'd1);
            chk($sformatf("v%0d_cycles", v), cyc, vt[v].cyc);
            chk($sformatf("v%0d_pc_we", v), npc, vt[v].npc);
            chk($sformatf("v%0d_rf_we", v), nrf, vt[v].nrf);
            chk($sformatf("v%0d_ldr_we", v), nldr, vt[v].nldr);
            chk($sformatf("v%0d_mem_we", v), nwe, vt[v].nwe);
            chk($sformatf("v%0d_wb_sel", v), wbs, vt[v].wbs);
            chk($sformatf("v%0d_src_b", v), sb, vt[v].sb);
            chk($sformatf("v%0d_mem_phase", v), bad, 0);
            dr = retired_out - r0;
            chk($sformatf("v%0d_retire", v), {28'd0, dr}, 32'd1);
        end

        // Counter wrap after 16 retirements.
        do_reset();
        for (int i = 0; i < 15; i++) model_instr(1, 0, 0, 1'b0);
        chk("wrap_15", {28'd0, retired_out}, 32'd15);
        model_instr(0, 0, 0, 1'b0);
        chk("wrap_16_to_0", {28'd0, retired_out}, 32'd0);

        // Reset in the middle of a waiting MEM phase.
        model_instr(1, 0, 0, 1'b0);
        instr_in = 32'h0000A103;
        mem_ready_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready_in = 1'b0;
        #1;
        chk("midmem_state", {29'd0, state_out}, 32'd3);
        chk("midmem_req", {30'd0, mem_req_out, mem_addr_sel_out}, 32'd3);
        chk("midmem_retired", {28'd0, retired_out}, 32'd1);
        rst_in = 1'b1;
        #1;
        chk("midmem_req_drop", {31'd0, mem_req_out}, 32'd0);
        @(posedge clk); #1;
        rst_in = 1'b0;
        model_cnt = 0;
        #1;
        chk("midmem_after_state", {29'd0, state_out}, 32'd0);
        chk("midmem_after_retired", {28'd0, retired_out}, 32'd0);
        @(posedge clk); #1;
        do_reset();

        // Illegal opcode: trap, held, retire count frozen, cleared by reset.
        model_instr(4, 0, 0, 1'b1);
        instr_in = 32'h0000007F;
        mem_ready_in = 1'b1;
        @(posedge clk); #1;
        #1;
        chk("trap_decode", {29'd0, state_out}, 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            mem_ready_in = rb();
            branch_taken_in = rb();
            #1;
            chk("trap_hold", {14'd0, pack_out()}, {14'd0, 3'd5, 8'd0, 2'd0, 1'b1, 4'd1});
            @(posedge clk); #1;
        end
        do_reset();
        #1;
        chk("trap_cleared", {28'd0, state_out, illegal_out}, 32'd0);

        // Randomized instruction stream against the trace model.
        for (int n = 0; n < 300; n++) begin
            model_instr($urandom_range(0, 5), $urandom_range(0, 3),
                        $urandom_range(0, 3), rb());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case a wait escapes its bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
